sd_write: RTL and testbench
===========================

// Module: sd_write
// PURPOSE
//  SPI-mode single-block writer (CMD24): writes one 512-byte block to the SD card at byte addr; companion of sd_read.
//  Sits beside sd_init/sd_read under the SD toplevel; shares the CS/D1(MOSI)/D0(MISO) pins via the top-level mux.
//  Pulls payload bytes from a valid/ready stream and reports R1 flags, error code and a level done handshake.
// PARAMETERS
//  CLK_DIV   4      clk cycles per SCLK half-period (>=1)
//  NCR_MAX   8      max 0xFF bytes polled for R1 before timeout
//  BUSY_MAX  65535  max bytes polled for busy release before timeout
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  start       in   1   level request; sampled only in IDLE
//  addr        in   32  card byte address, sent MSB first in CMD24
//  wr_data     in   8   payload byte, block byte 0 first
//  wr_valid    in   1   wr_data valid
//  wr_ready    out  1   byte consumed this cycle when wr_valid&wr_ready
//  done        out  1   high in DONE until start drops
//  busy        out  1   high in every state except IDLE/DONE
//  err_code    out  3   0 ok,1 R1 timeout,2 R1!=0,3 CRC reject,4 write-error reject,5 bad token,6 busy timeout
//  resp_flags  out  8   last R1 byte received
//  sclk        out  1   SPI clock, mode 0, idle low
//  cs          out  1   chip select, active low
//  mosi        out  1   D1; idles high
//  miso        in   1   D0
// BEHAVIOUR
//  Reset: cs=1, sclk=0, mosi=1, wr_ready=0, done=0, busy=0, err_code=0, resp_flags=0, state IDLE; aborts any transfer mid-byte, no further SCLK edges.
//  Byte engine: 8 bits MSB first; mosi changes while sclk low, miso sampled on sclk rising edge; 16*CLK_DIV clk per byte.
//  States: IDLE -> CMD -> NCR -> GAP -> TOKEN -> DATA -> CRC -> DRESP -> BUSYW -> TAIL -> DONE.
//  IDLE: start=1 -> clear err_code, latch addr, cs=0 next cycle, go CMD.
//  CMD: send 0x58, addr[31:24..7:0], 0xFF (CRC ignored in SPI mode).
//  NCR: send 0xFF, capture; first byte with bit7=0 -> resp_flags; ==0x00 -> GAP, else err 2 -> TAIL; NCR_MAX bytes all 0xFF -> err 1 -> TAIL.
//  GAP: one 0xFF byte. TOKEN: send 0xFE.
//  DATA: 512 bytes; wr_ready high exactly one cycle when engine needs next byte and wr_valid=1; if wr_valid=0, hold sclk low (stall), no bit lost.
//  Byte counter 9 bits, 0..511; wrap to 0 leaves DATA; byte 512 never requested.
//  CRC: two bytes 0xFF,0xFF (see CONFIGURATION).
//  DRESP: send 0xFF, read byte; bits[4:0]: 00101 accept -> BUSYW; 01011 -> err 3; 01101 -> err 4; other -> err 5; errors -> TAIL.
//  BUSYW: send 0xFF until received byte != 0x00 -> TAIL; BUSY_MAX bytes of 0x00 -> err 6 -> TAIL.
//  TAIL: cs=1, one 0xFF byte (8 clocks) with cs high, then DONE.
//  DONE: done=1, busy=0, err_code/resp_flags held; start=0 -> IDLE next cycle; start held high never re-triggers.
//  start dropped mid-transfer is ignored; only reset aborts.
// CONFIGURATION
//  SD_WRITE_CRC16_EN defined: CRC-16-CCITT (poly 0x1021, init 0x0000) over the 512 data bytes, sent MSB byte first in CRC state.
//  Undefined: CRC bytes are constant 0xFF,0xFF; no CRC logic synthesized. All other timing identical.
// TESTING (card model on D0/D1/CS)
//  addr=0x200, model R1=0x00, resp 0xE5, 3 busy bytes -> MOSI 58 00 00 02 00 FF, FE, 512 bytes, done=1, err_code=0.
//  Model never answers (miso=1) -> exactly 8 NCR bytes, err_code=1, resp_flags=0, cs high, done=1.
//  R1=0x04 -> err_code=2, resp_flags=0x04, no 0xFE token sent.
//  wr_valid low 100 cycles at byte 37 -> sclk stays low, byte 37 sent intact; model captures 512 bytes matching source.
//  Data response 0x0B -> err_code=3; 0x0D -> err_code=4; busy 0x00 forever (BUSY_MAX=16) -> err_code=6.
//  reset asserted during DATA byte 200 -> next cycle cs=1, sclk=0, busy=0; new start runs clean write.
//  SD_WRITE_CRC16_EN, all-0xFF block -> CRC bytes 0x7F,0xA1.

Source files
------------

// File: rtl/sd_write.sv
// sd_write: SPI-mode single-block writer (CMD24) for an SD card.
// Sends CMD24 with a byte address and waits for R1. It then streams a 512-byte
// block from a valid/ready source, reads the data response and waits for the
// card to release busy. A level done/start handshake closes the transfer.
// Optional feature: define SD_WRITE_CRC16_EN to send a real CRC-16-CCITT over
// the payload. Without it, the two CRC bytes are 0xFF,0xFF.
module sd_write #(
  parameter int CLK_DIV  = 4,
  parameter int NCR_MAX  = 8,
  parameter int BUSY_MAX = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        done,
  output logic        busy,
  output logic [2:0]  err_code,
  output logic [7:0]  resp_flags,
  output logic        sclk,
  output logic        cs,
  output logic        mosi,
  input  logic        miso
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0]   NCR_LAST  = 16'(NCR_MAX - 1);
  localparam logic [15:0]   BUSY_LAST = 16'(BUSY_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_NCR, S_GAP, S_TOKEN, S_DATA,
    S_CRC, S_DRESP, S_BUSYW, S_TAIL, S_DONE
  } state_t;

  // byte engine
  logic          eng_act;
  logic [DW-1:0] div_cnt;
  logic [3:0]    hcnt;      // SCLK half-period index within the byte
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          tick;
  logic          eng_fin;   // last half-period of a byte ends this cycle
  logic          ld;
  logic [7:0]    ld_byte;

  // control
  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;     // per-state byte counter (CMD/NCR/CRC/BUSYW)
  logic [8:0]  bcnt, bcnt_d;   // payload byte index
  logic [31:0] addr_q, addr_d;
  logic [2:0]  err_d;
  logic [7:0]  flags_d;
  logic        cs_d;
  logic [7:0]  cmd_byte;

`ifdef SD_WRITE_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign tick    = (div_cnt == DIV_LAST);
  assign eng_fin = eng_act && tick && (hcnt == 4'd15);
  assign done    = (state == S_DONE);
  assign busy    = (state != S_IDLE) && (state != S_DONE);

  // CMD24 frame bytes: opcode, address MSB first, dummy CRC
  always_comb begin
    case (cnt[2:0])
      3'd0:    cmd_byte = 8'h58;
      3'd1:    cmd_byte = addr_q[31:24];
      3'd2:    cmd_byte = addr_q[23:16];
      3'd3:    cmd_byte = addr_q[15:8];
      3'd4:    cmd_byte = addr_q[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  end

  // Shift engine: mode 0, mosi moves on falling edges, miso sampled on rising.
  // When idle it parks SCLK low and MOSI high, so stalls lose no bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_act <= 1'b0;
      div_cnt <= '0;
      hcnt    <= '0;
      tx_sr   <= 8'hFF;
      rx_sr   <= 8'hFF;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else if (ld) begin
      eng_act <= 1'b1;
      div_cnt <= '0;
      hcnt    <= '0;
      tx_sr   <= ld_byte;
      mosi    <= ld_byte[7];
      sclk    <= 1'b0;
    end else if (eng_act) begin
      if (tick) begin
        div_cnt <= '0;
        hcnt    <= hcnt + 4'd1;
        if (!hcnt[0]) begin
          sclk  <= 1'b1;
          rx_sr <= {rx_sr[6:0], miso};
        end else begin
          sclk  <= 1'b0;
          tx_sr <= {tx_sr[6:0], 1'b1};
          mosi  <= tx_sr[6];
          if (hcnt == 4'd15) begin
            eng_act <= 1'b0;
            mosi    <= 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Next-state logic: each state loads a byte when the engine is idle and
  // acts on the received byte when the engine finishes it.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bcnt_d   = bcnt;
    addr_d   = addr_q;
    err_d    = err_code;
    flags_d  = resp_flags;
    cs_d     = cs;
    ld       = 1'b0;
    ld_byte  = 8'hFF;
    wr_ready = 1'b0;
`ifdef SD_WRITE_CRC16_EN
    crc_d    = crc_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          err_d   = 3'd0;
          addr_d  = addr;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!eng_act) begin
          ld      = 1'b1;
          ld_byte = cmd_byte;
        end
        if (eng_fin) begin
          if (cnt == 16'd5) begin
            cnt_d   = '0;
            state_d = S_NCR;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_NCR: begin
        if (!eng_act) ld = 1'b1;
        if (eng_fin) begin
          if (!rx_sr[7]) begin
            flags_d = rx_sr;
            if (rx_sr == 8'h00) begin
              state_d = S_GAP;
            end else begin
              err_d   = 3'd2;
              cs_d    = 1'b1;
              state_d = S_TAIL;
            end
          end else if (cnt == NCR_LAST) begin
            err_d   = 3'd1;
            cs_d    = 1'b1;
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (!eng_act) ld = 1'b1;
        if (eng_fin) state_d = S_TOKEN;
      end
      S_TOKEN: begin
        if (!eng_act) begin
          ld      = 1'b1;
          ld_byte = 8'hFE;
        end
        if (eng_fin) begin
          bcnt_d  = '0;
          state_d = S_DATA;
`ifdef SD_WRITE_CRC16_EN
          crc_d   = 16'h0000;
`endif
        end
      end
      S_DATA: begin
        if (!eng_act && wr_valid) begin
          ld       = 1'b1;
          ld_byte  = wr_data;
          wr_ready = 1'b1;
`ifdef SD_WRITE_CRC16_EN
          crc_d    = crc16_byte(crc_q, wr_data);
`endif
        end
        if (eng_fin) begin
          bcnt_d = bcnt + 9'd1;
          if (bcnt_d == 9'd0) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (!eng_act) begin
          ld = 1'b1;
`ifdef SD_WRITE_CRC16_EN
          ld_byte = (cnt == 16'd0) ? crc_q[15:8] : crc_q[7:0];
`else
          ld_byte = 8'hFF;
`endif
        end
        if (eng_fin) begin
          if (cnt == 16'd1) begin
            cnt_d   = '0;
            state_d = S_DRESP;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_DRESP: begin
        if (!eng_act) ld = 1'b1;
        if (eng_fin) begin
          case (rx_sr[4:0])
            5'b00101: begin
              cnt_d   = '0;
              state_d = S_BUSYW;
            end
            5'b01011: err_d = 3'd3;
            5'b01101: err_d = 3'd4;
            default:  err_d = 3'd5;
          endcase
          if (rx_sr[4:0] != 5'b00101) begin
            cs_d    = 1'b1;
            state_d = S_TAIL;
          end
        end
      end
      S_BUSYW: begin
        if (!eng_act) ld = 1'b1;
        if (eng_fin) begin
          if (rx_sr != 8'h00) begin
            cs_d    = 1'b1;
            state_d = S_TAIL;
          end else if (cnt == BUSY_LAST) begin
            err_d   = 3'd6;
            cs_d    = 1'b1;
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_TAIL: begin
        if (!eng_act) ld = 1'b1;
        if (eng_fin) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      addr_q     <= '0;
      err_code   <= '0;
      resp_flags <= '0;
      cs         <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bcnt       <= bcnt_d;
      addr_q     <= addr_d;
      err_code   <= err_d;
      resp_flags <= flags_d;
      cs         <= cs_d;
    end
  end

`ifdef SD_WRITE_CRC16_EN
  // Running payload CRC
  always_ff @(posedge clk) begin
    if (reset) crc_q <= 16'h0000;
    else       crc_q <= crc_d;
  end
`endif

endmodule

// File: tb/tb_sd_write.sv
// tb_sd_write: directed bench for sd_write with a byte-level SD card model.
module tb_sd_write;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready, done, busy, sclk, cs, mosi, miso;
  logic [2:0]  err_code;
  logic [7:0]  resp_flags;

  sd_write #(.CLK_DIV(1), .NCR_MAX(8), .BUSY_MAX(16)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done(done), .busy(busy), .err_code(err_code), .resp_flags(resp_flags),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- card model ----------------
  logic [7:0] cfg_r1, cfg_dresp;
  int         cfg_busy_n;
  bit         cfg_busy_forever;
  logic [7:0] mtsh = 8'hFF, mrsh = 8'h00, mnxt = 8'hFF;
  bit         mpend = 0, tok_seen = 0;
  int         mbit = 0, mtot = 0, mphase = 0, mdcnt = 0, mccnt = 0, mbsent = 0;
  int         tail_edges = 0;
  logic [7:0] cmd_cap [6];
  logic [7:0] data_cap [512];
  logic [7:0] crc_cap [2];

  assign miso = cs ? 1'b1 : mtsh[7];

  always @(negedge cs) begin
    mbit = 0; mtot = 0; mphase = 0; mdcnt = 0; mccnt = 0; mbsent = 0;
    tok_seen = 0; mpend = 0; mtsh = 8'hFF;
  end

  always @(posedge sclk) begin
    if (cs) tail_edges++;
    else begin
      mrsh = {mrsh[6:0], mosi};
      mbit++;
      if (mbit == 8) begin
        mbit = 0;
        mtot++;
        mnxt = 8'hFF;
        case (mphase)
          0: begin
            if (mtot <= 6) cmd_cap[mtot-1] = mrsh;
            if (mtot == 7) mnxt = cfg_r1;
            if (mtot >= 8 && mrsh == 8'hFE) begin mphase = 1; tok_seen = 1; end
          end
          1: begin
            data_cap[mdcnt] = mrsh;
            mdcnt++;
            if (mdcnt == 512) mphase = 2;
          end
          2: begin
            crc_cap[mccnt] = mrsh;
            mccnt++;
            if (mccnt == 2) begin mnxt = cfg_dresp; mphase = 3; end
          end
          default: begin
            if (cfg_busy_forever || mbsent < cfg_busy_n) begin mnxt = 8'h00; mbsent++; end
          end
        endcase
        mpend = 1;
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs) begin
      if (mpend) begin mtsh = mnxt; mpend = 0; end
      else mtsh = {mtsh[6:0], 1'b1};
    end
  end

  // ---------------- payload source ----------------
  logic [7:0] src [512];
  int  sidx = 0, stall_left = 0, stall_hi = 0;
  bit  feed_en = 0, stall_en = 0, stalled = 0, hs;

  initial begin
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (hs) sidx++;
      if (stall_en && sidx == 37 && !stalled) begin stalled = 1; stall_left = 100; end
      if (stall_left > 0 && stall_left <= 50 && sclk) stall_hi++;
      if (stall_left > 0) begin stall_left--; wr_valid = 1'b0; end
      else wr_valid = feed_en;
      wr_data = (sidx < 512) ? src[sidx] : 8'h00;
    end
  end

  function automatic logic [15:0] tb_crc();
    logic [15:0] c = 16'h0000;
    logic fb;
    for (int k = 0; k < 512; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ src[k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  r1;
    logic [7:0]  dresp;
    int          busy_n;
    bit          busy_forever;
    bit          stall;
    bit          fill_ff;
    bit          full;
    bit          exp_tok;
    logic [2:0]  exp_err;
    logic [7:0]  exp_flags;
    int          exp_tot;
  } vec_t;

  function automatic vec_t mk(logic [31:0] a, logic [7:0] r1, logic [7:0] dr, int bn,
                              bit bf, bit st, bit ff, bit full, bit tok,
                              logic [2:0] e, logic [7:0] fl, int tot);
    vec_t v;
    v.addr = a; v.r1 = r1; v.dresp = dr; v.busy_n = bn; v.busy_forever = bf;
    v.stall = st; v.fill_ff = ff; v.full = full; v.exp_tok = tok;
    v.exp_err = e; v.exp_flags = fl; v.exp_tot = tot;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n, bad;
    logic [15:0] ecrc;
    cfg_r1 = v.r1; cfg_dresp = v.dresp; cfg_busy_n = v.busy_n; cfg_busy_forever = v.busy_forever;
    for (int k = 0; k < 512; k++) src[k] = v.fill_ff ? 8'hFF : 8'((k * 7 + 3) ^ (k >> 3));
    @(negedge clk);
    sidx = 0; stalled = 0; stall_en = v.stall; stall_hi = 0; tail_edges = 0;
    addr = v.addr; feed_en = 1; start = 1'b1;
    n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    chk({tag, " done"}, done, 1);
    chk({tag, " err_code"}, err_code, v.exp_err);
    chk({tag, " resp_flags"}, resp_flags, v.exp_flags);
    chk({tag, " cs_high"}, cs, 1);
    chk({tag, " bytes"}, mtot, v.exp_tot);
    chk({tag, " token"}, tok_seen, v.exp_tok);
    chk({tag, " tail_edges"}, tail_edges, 8);
    chk({tag, " cmd"}, {cmd_cap[0], cmd_cap[1], cmd_cap[2], cmd_cap[3], cmd_cap[4], cmd_cap[5]},
        {8'h58, v.addr, 8'hFF});
    if (v.full) begin
      bad = 0;
      for (int k = 0; k < 512; k++) if (data_cap[k] !== src[k]) bad++;
      chk({tag, " data_bad"}, bad, 0);
      chk({tag, " consumed"}, sidx, 512);
`ifdef SD_WRITE_CRC16_EN
      ecrc = tb_crc();
      if (v.fill_ff) chk({tag, " crc_ff"}, {crc_cap[0], crc_cap[1]}, 16'h7FA1);
`else
      ecrc = 16'hFFFF;
`endif
      chk({tag, " crc"}, {crc_cap[0], crc_cap[1]}, ecrc);
    end
    if (v.stall) chk({tag, " stall_sclk"}, stall_hi, 0);
    feed_en = 0;
    // start held high must not retrigger
    repeat (20) @(negedge clk);
    chk({tag, " hold"}, {done, busy, cs}, 3'b101);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, " idle"}, {done, busy}, 2'b00);
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    vecs[0] = mk(32'h0000_0200, 8'h00, 8'hE5, 3, 0, 0, 0, 1, 1, 3'd0, 8'h00, 529);
    vecs[1] = mk(32'h1234_5678, 8'hFF, 8'hE5, 3, 0, 0, 0, 0, 0, 3'd1, 8'h00, 14);
    vecs[2] = mk(32'hDEAD_BE00, 8'h04, 8'hE5, 3, 0, 0, 0, 0, 0, 3'd2, 8'h04, 8);
    vecs[3] = mk(32'h0000_0400, 8'h00, 8'hE5, 3, 0, 1, 0, 1, 1, 3'd0, 8'h00, 529);
    vecs[4] = mk(32'h0000_0600, 8'h00, 8'h0B, 0, 0, 0, 0, 1, 1, 3'd3, 8'h00, 525);
    vecs[5] = mk(32'h0000_0800, 8'h00, 8'h0D, 0, 0, 0, 0, 1, 1, 3'd4, 8'h00, 525);
    vecs[6] = mk(32'h0000_0A00, 8'h00, 8'hE5, 0, 1, 0, 0, 1, 1, 3'd6, 8'h00, 541);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {cs, sclk, mosi, wr_ready, done, busy, err_code, resp_flags},
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00});

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // abort during payload byte 200, then a clean all-0xFF write
    cfg_r1 = 8'h00; cfg_dresp = 8'hE5; cfg_busy_n = 1; cfg_busy_forever = 0;
    for (int k = 0; k < 512; k++) src[k] = 8'(k);
    @(negedge clk);
    sidx = 0; stalled = 0; stall_en = 0; feed_en = 1; addr = 32'h0000_0C00; start = 1'b1;
    n = 0;
    while (sidx < 201 && n < 10000) begin @(negedge clk); n++; end
    chk("abort reached_byte200", sidx >= 201, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort outputs", {cs, sclk, busy, wr_ready}, 4'b1000);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; feed_en = 0;
    repeat (5) @(negedge clk);
    chk("abort quiet", {cs, sclk, busy, done}, 4'b1000);
    run_vec(mk(32'h0000_0E00, 8'h00, 8'hE5, 1, 0, 0, 1, 1, 1, 3'd0, 8'h00, 527), "clean");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
